// File: rtl/particle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : particle_scheduler
// Description : Walks a frame's worth of particles out of a latency-L memory,
//               culls those at or behind the near plane, and hands the rest to
//               a projector over a ready/valid-pulse handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module particle_scheduler #(
  parameter int                 NUM_PARTICLES = 64,
  parameter int                 ADDR_WIDTH    = 8,
  parameter int                 MEM_LATENCY   = 2,
  parameter logic signed [15:0] NEAR_Z        = 16'sd16
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  frame_start_in,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_rd_en_out,
  input  logic [47:0]           mem_data_in,
  input  logic                  projector_ready_in,
  output logic [15:0]           f_x_out,
  output logic [15:0]           f_y_out,
  output logic [15:0]           f_z_out,
  output logic                  data_valid_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [ADDR_WIDTH:0]   cull_count_out,
  output logic                  overrun_out
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_WAIT_MEM = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_HOLDOFF  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Wait counter runs 0..MEM_LATENCY-1; capture happens on its last value.
  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0]     c_WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);
  localparam logic [WAIT_W-1:0]     c_WAIT_ONE  = WAIT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX  = ADDR_WIDTH'(NUM_PARTICLES - 1);
  localparam logic [ADDR_WIDTH-1:0] c_IDX_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   c_CULL_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [WAIT_W-1:0]     r_wait;
  logic [ADDR_WIDTH:0]   r_cull;
  logic [15:0]           r_fx;
  logic [15:0]           r_fy;
  logic [15:0]           r_fz;
  logic                  r_overrun;

  logic                  w_last;
  logic signed [15:0]    w_z;
  logic                  w_cull;

  assign w_last = (r_index == c_LAST_IDX);
  assign w_z    = mem_data_in[15:0];
  assign w_cull = (w_z <= NEAR_Z);

  // Frame walker: fetch, wait out memory latency, cull or issue, advance.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_wait  <= '0;
      r_cull  <= '0;
      r_fx    <= '0;
      r_fy    <= '0;
      r_fz    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start_in) begin
            r_index <= '0;
            r_cull  <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_wait  <= '0;
          r_state <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          if (r_wait == c_WAIT_LAST) begin
            r_fx <= mem_data_in[47:32];
            r_fy <= mem_data_in[31:16];
            r_fz <= mem_data_in[15:0];
            if (!w_cull) begin
              r_state <= S_ISSUE;
            end else begin
              // Culled particles skip the projector and advance directly.
              r_cull <= r_cull + c_CULL_ONE;
              if (w_last) begin
                r_state <= S_DONE;
              end else begin
                r_index <= r_index + c_IDX_ONE;
                r_state <= S_FETCH;
              end
            end
          end else begin
            r_wait <= r_wait + c_WAIT_ONE;
          end
        end
        S_ISSUE: begin
          if (projector_ready_in) begin
            r_state <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          // One dead cycle lets the projector drop ready after accepting.
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_index <= r_index + c_IDX_ONE;
            r_state <= S_FETCH;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag: any start request while a frame is in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_overrun <= 1'b0;
    end else if (frame_start_in && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  // Strobes decode straight from state so they are one cycle wide by construction.
  assign mem_rd_en_out  = (r_state == S_FETCH);
  assign data_valid_out = (r_state == S_ISSUE) && projector_ready_in;
  assign frame_done_out = (r_state == S_DONE);
  assign busy_out       = (r_state != S_IDLE);
  assign mem_addr_out   = r_index;
  assign cull_count_out = r_cull;
  assign overrun_out    = r_overrun;
  assign f_x_out        = r_fx;
  assign f_y_out        = r_fy;
  assign f_z_out        = r_fz;

endmodule
`default_nettype wire

// File: tb/tb_particle_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_particle_scheduler
// Description : Self-checking bench for particle_scheduler with a latency-2
//               memory model and a frame-level expected-result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_particle_scheduler;

  localparam int                 NP   = 4;
  localparam int                 AW   = 4;
  localparam int                 LAT  = 2;
  localparam logic signed [15:0] NEAR = 16'sd16;
  localparam logic [47:0]        POISON = 48'hDEAD_BEEF_7FFF;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          frame_start_in = 1'b0;
  logic          projector_ready_in = 1'b0;
  logic [AW-1:0] mem_addr_out;
  logic          mem_rd_en_out;
  logic [47:0]   mem_data_in;
  logic [15:0]   f_x_out, f_y_out, f_z_out;
  logic          data_valid_out, busy_out, frame_done_out, overrun_out;
  logic [AW:0]   cull_count_out;

  particle_scheduler #(
    .NUM_PARTICLES(NP),
    .ADDR_WIDTH   (AW),
    .MEM_LATENCY  (LAT),
    .NEAR_Z       (NEAR)
  ) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .frame_start_in    (frame_start_in),
    .mem_addr_out      (mem_addr_out),
    .mem_rd_en_out     (mem_rd_en_out),
    .mem_data_in       (mem_data_in),
    .projector_ready_in(projector_ready_in),
    .f_x_out           (f_x_out),
    .f_y_out           (f_y_out),
    .f_z_out           (f_z_out),
    .data_valid_out    (data_valid_out),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .cull_count_out    (cull_count_out),
    .overrun_out       (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Particle memory: data for a read appears LAT cycles after the strobe;
  // any other cycle presents a poison word that would be issued if captured.
  logic [47:0] mem [0:15];
  logic [47:0] pipe0 = '0;
  logic [47:0] pipe1 = '0;
  always @(posedge clk_in) begin
    pipe0 <= mem_rd_en_out ? mem[mem_addr_out] : POISON;
    pipe1 <= pipe0;
  end
  assign mem_data_in = pipe1;

  // ---------------- counters and model state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    int          addr;
    int          at;
  } exp_t;

  exp_t q[$];
  logic m_busy = 1'b0;
  logic m_ovr  = 1'b0;
  logic m_tied = 1'b0;
  logic tied   = 1'b1;
  int   m_cull = 0;
  int   m_fetch_next = 0;
  int   m_done_cyc = 0;
  int   m_acc_cyc = 0;
  int   n_dv = 0;
  int   log_cyc [8];
  int   log_addr [8];
  logic [15:0] log_fx [8];
  logic [15:0] log_fy [8];
  logic [15:0] log_fz [8];
  int   log_done_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame outcome computed from memory contents and the scheduling rules.
  task automatic build_frame();
    exp_t e;
    int t;
    logic signed [15:0] zz;
    q.delete();
    m_cull = 0;
    m_fetch_next = 0;
    n_dv = 0;
    m_acc_cyc = cyc;
    m_tied = tied;
    t = cyc + 1;
    for (int i = 0; i < NP; i++) begin
      zz = mem[i][15:0];
      if (zz <= NEAR) begin
        m_cull++;
        t += 1 + LAT;
      end else begin
        e.x = mem[i][47:32];
        e.y = mem[i][31:16];
        e.z = mem[i][15:0];
        e.addr = i;
        e.at = t + LAT + 1;
        q.push_back(e);
        t += LAT + 3;
      end
    end
    m_done_cyc = t;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  task automatic monitor();
    exp_t e;
    logic busy_nx;
    if (!rst_n_in) begin
      q.delete();
      m_busy = 1'b0;
      m_ovr = 1'b0;
      m_cull = 0;
      m_fetch_next = 0;
      return;
    end
    busy_nx = m_busy;
    check("busy", 64'(busy_out), 64'(m_busy));
    check("overrun", 64'(overrun_out), 64'(m_ovr));
    if (!m_busy) check("cull_hold", 64'(cull_count_out), 64'(m_cull));
    check("rd_and_valid_exclusive", 64'(mem_rd_en_out && data_valid_out), 64'(0));
    if (mem_rd_en_out) begin
      check("fetch_in_frame", 64'(m_busy), 64'(1));
      check("fetch_addr", 64'(mem_addr_out), 64'(m_fetch_next));
      m_fetch_next++;
    end
    if (data_valid_out) begin
      check("valid_with_ready", 64'(projector_ready_in), 64'(1));
      check("valid_expected", 64'(q.size() > 0), 64'(1));
      if (q.size() > 0) begin
        e = q.pop_front();
        check("issue_x", 64'(f_x_out), 64'(e.x));
        check("issue_y", 64'(f_y_out), 64'(e.y));
        check("issue_z", 64'(f_z_out), 64'(e.z));
        check("issue_addr", 64'(mem_addr_out), 64'(e.addr));
        if (m_tied) check("issue_cycle", 64'(cyc), 64'(e.at));
      end
      if (n_dv < 8) begin
        log_cyc[n_dv] = cyc;
        log_addr[n_dv] = int'(mem_addr_out);
        log_fx[n_dv] = f_x_out;
        log_fy[n_dv] = f_y_out;
        log_fz[n_dv] = f_z_out;
      end
      n_dv++;
    end
    if (frame_done_out) begin
      check("done_in_frame", 64'(m_busy), 64'(1));
      check("done_all_issued", 64'(q.size()), 64'(0));
      check("done_fetch_count", 64'(m_fetch_next), 64'(NP));
      check("done_cull_count", 64'(cull_count_out), 64'(m_cull));
      if (m_tied) check("done_cycle", 64'(cyc), 64'(m_done_cyc));
      log_done_cyc = cyc;
      busy_nx = 1'b0;
    end
    if (frame_start_in) begin
      if (m_busy) m_ovr = 1'b1;
      else begin
        build_frame();
        busy_nx = 1'b1;
      end
    end
    m_busy = busy_nx;
  endtask

  task automatic step();
    @(negedge clk_in);
    monitor();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic start_frame();
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      step();
      n++;
    end
    check("frame_finishes", 64'(m_busy), 64'(0));
  endtask

  task automatic set_all(input logic [15:0] z0, input logic [15:0] z1,
                         input logic [15:0] z2, input logic [15:0] z3);
    mem[0] = {16'h0A00, 16'h0B00, z0};
    mem[1] = {16'h0A11, 16'h0B11, z1};
    mem[2] = {16'h0A22, 16'h0B22, z2};
    mem[3] = {16'h0A33, 16'h0B33, z3};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 64'(mem_addr_out), 64'(0));
    check({tag, "_rd"}, 64'(mem_rd_en_out), 64'(0));
    check({tag, "_fxyz"}, 64'({f_x_out, f_y_out, f_z_out}), 64'(0));
    check({tag, "_valid"}, 64'(data_valid_out), 64'(0));
    check({tag, "_busy"}, 64'(busy_out), 64'(0));
    check({tag, "_done"}, 64'(frame_done_out), 64'(0));
    check({tag, "_cull"}, 64'(cull_count_out), 64'(0));
    check({tag, "_overrun"}, 64'(overrun_out), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {16'hEEEE, 16'hEEEE, 16'sd100};
    projector_ready_in = 1'b1;

    // Reset state
    repeat (3) step();
    check_all_zero("reset");
    rst_n_in = 1'b1;
    repeat (2) step();

    // Frame 1: every particle visible, ready tied high
    tied = 1'b1;
    set_all(16'sd100, 16'sd100, 16'sd100, 16'sd100);
    start_frame();
    wait_done(200);
    check("t1_pulses", 64'(n_dv), 64'(4));
    check("t1_first_latency", 64'(log_cyc[0] - m_acc_cyc), 64'(4));
    check("t1_spacing", 64'(log_cyc[1] - log_cyc[0]), 64'(5));
    check("t1_last_addr", 64'(log_addr[3]), 64'(3));
    check("t1_done_cycle", 64'(log_done_cyc - m_acc_cyc), 64'(21));
    check("t1_cull", 64'(cull_count_out), 64'(0));
    repeat (2) step();

    // Frame 2: mixed culling
    set_all(16'sd100, 16'sd16, -16'sd5, 16'sd200);
    start_frame();
    wait_done(200);
    check("t2_pulses", 64'(n_dv), 64'(2));
    check("t2_addr0", 64'(log_addr[0]), 64'(0));
    check("t2_addr1", 64'(log_addr[1]), 64'(3));
    check("t2_fz_second", 64'(log_fz[1]), 64'(200));
    check("t2_second_cycle", 64'(log_cyc[1] - m_acc_cyc), 64'(15));
    check("t2_done_cycle", 64'(log_done_cyc - m_acc_cyc), 64'(17));
    check("t2_cull", 64'(cull_count_out), 64'(2));
    repeat (3) step();

    // Frame 3: projector stalls for 10 cycles in ISSUE
    tied = 1'b0;
    projector_ready_in = 1'b0;
    set_all(16'sd100, 16'sd100, 16'sd100, 16'sd100);
    start_frame();
    while (cyc < m_acc_cyc + 4) step();
    for (int k = 0; k < 10; k++) begin
      check("stall_no_valid", 64'(data_valid_out), 64'(0));
      check("stall_f_stable", 64'({f_x_out, f_y_out, f_z_out}), 64'(mem[0]));
      step();
    end
    projector_ready_in = 1'b1;
    #1;
    check("stall_release_valid", 64'(data_valid_out), 64'(1));
    step();
    wait_done(200);
    check("t3_pulses", 64'(n_dv), 64'(4));
    tied = 1'b1;

    // Frame 4: z boundaries plus a start request mid-frame
    set_all(16'sd17, 16'sd16, 16'h8000, 16'h7FFF);
    start_frame();
    while (cyc < m_acc_cyc + 7) step();
    frame_start_in = 1'b1;
    step();
    frame_start_in = 1'b0;
    wait_done(200);
    check("t4_pulses", 64'(n_dv), 64'(2));
    check("t4_addr1", 64'(log_addr[1]), 64'(3));
    check("t4_fz_first", 64'(log_fz[0]), 64'(17));
    check("t4_cull", 64'(cull_count_out), 64'(2));
    check("t4_overrun", 64'(overrun_out), 64'(1));
    repeat (2) step();

    // Frame 5: overrun stays set through a clean frame
    set_all(16'sd100, 16'sd100, 16'sd100, 16'sd100);
    start_frame();
    wait_done(200);
    check("t5_overrun_sticky", 64'(overrun_out), 64'(1));

    // Frame 6: reset during WAIT_MEM of particle 2
    start_frame();
    while (cyc < m_acc_cyc + 12) step();
    check("t6_in_wait_addr", 64'(mem_addr_out), 64'(2));
    check("t6_in_wait_busy", 64'(busy_out), 64'(1));
    rst_n_in = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (3) step();
    rst_n_in = 1'b1;
    repeat (3) step();

    // Frame 7: field mapping after reset, restart from address 0
    mem[0] = {16'h1234, 16'h5678, 16'h0040};
    start_frame();
    wait_done(200);
    check("t7_pulses", 64'(n_dv), 64'(4));
    check("t7_first_addr", 64'(log_addr[0]), 64'(0));
    check("t7_fx", 64'(log_fx[0]), 64'(16'h1234));
    check("t7_fy", 64'(log_fy[0]), 64'(16'h5678));
    check("t7_fz", 64'(log_fz[0]), 64'(16'h0040));
    check("t7_overrun_cleared", 64'(overrun_out), 64'(0));
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
